// File: rtl/gnn_pkg.sv
// Shared sizing, frame layout and loader state encoding for the gnn input loader.
package gnn_pkg;

  localparam int WORD_W      = 16;
  localparam int N_NODE      = 4;
  localparam int N_FEAT      = 4;
  localparam int N_HID       = 4;
  localparam int N_OUT       = 2;
  localparam int FRAME_WORDS = 40;

  localparam int X_WORDS  = N_NODE * N_FEAT;
  localparam int W1_WORDS = N_FEAT * N_HID;
  localparam int W2_WORDS = N_HID * N_OUT;

  localparam int X_W     = X_WORDS * WORD_W;
  localparam int W1_W    = W1_WORDS * WORD_W;
  localparam int W2_W    = W2_WORDS * WORD_W;
  localparam int STAGE_W = FRAME_WORDS * WORD_W;

  localparam int CNT_W    = $clog2(FRAME_WORDS);
  localparam int SLOT_SH  = $clog2(WORD_W);
  localparam int RDY_W    = 2 * N_NODE;
  localparam int TMR_W    = 16;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic all_ready(input logic [RDY_W-1:0] rdy);
    return &rdy;
  endfunction

endpackage

// File: rtl/gnn_frame_cnt.sv
// Word index within a frame; flags the clean final word and framing errors.
module gnn_frame_cnt
  import gnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             last,
  output logic [CNT_W-1:0] idx,
  output logic             frame_done,
  output logic             frame_bad
);

  logic at_end;

  assign at_end     = (idx == CNT_W'(FRAME_WORDS - 1));
  assign frame_done = accept && at_end && last;
  // s_last must coincide exactly with the final word; either mismatch is an error
  assign frame_bad  = accept && (at_end != last);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (frame_done || frame_bad) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/gnn_in_loader.sv
// Streams 40-word frames into a staging buffer and hands them to the gnn core,
// sequencing in_ready through LOAD / RUN / GAP with a bounded RUN phase.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_LOAD | waiting for a complete frame (streamed or already staged)
//   ST_RUN  | in_ready high; waiting for all result flags or timeout
//   ST_GAP  | single idle cycle with in_ready low before next load
module gnn_in_loader
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [RDY_W-1:0]  out_rdy,
  output logic [X_W-1:0]    x_flat,
  output logic [W1_W-1:0]   w1_flat,
  output logic [W2_W-1:0]   w2_flat,
  output logic              in_ready,
  output logic              frame_err,
  output logic              timeout
);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_wr;
  logic               stage_full_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               run_first_q;
  logic [X_W-1:0]     x_q;
  logic [W1_W-1:0]    w1_q;
  logic [W2_W-1:0]    w2_q;
  logic               in_ready_q, frame_err_q, timeout_q;

  logic               accept;
  logic [CNT_W-1:0]   idx;
  logic               frame_done, frame_bad;
  logic               commit, set_full, tmo_hit, run_enter;

  assign s_ready = !stage_full_q;
  assign accept  = s_valid && s_ready;

  gnn_frame_cnt u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .last       (s_last),
    .idx        (idx),
    .frame_done (frame_done),
    .frame_bad  (frame_bad)
  );

  // Staging with the current word merged in, so a LOAD-state commit on word 39
  // already carries that word.
  always_comb begin
    stage_wr = stage_q;
    if (accept) begin
      stage_wr[{idx, {SLOT_SH{1'b0}}} +: WORD_W] = s_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    tmo_hit  = 1'b0;
    set_full = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (stage_full_q || frame_done) begin
          commit  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        set_full = frame_done;
        if (!run_first_q && all_ready(out_rdy)) begin
          state_d = ST_GAP;
        end else if (tmr_q == '0) begin
          tmo_hit = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        set_full = frame_done;
        state_d  = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign run_enter = (state_q != ST_RUN) && (state_d == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      tmr_q        <= '0;
      run_first_q  <= 1'b0;
      x_q          <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      in_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_wr;
      run_first_q <= run_enter;
      in_ready_q  <= (state_d == ST_RUN);
      frame_err_q <= frame_bad;
      timeout_q   <= tmo_hit;

      if (set_full) begin
        stage_full_q <= 1'b1;
      end else if (commit) begin
        stage_full_q <= 1'b0;
      end

      // Down-counter: RUN cycle n sees TIMEOUT-1-n, so zero marks the last allowed cycle
      if (run_enter) begin
        tmr_q <= TMR_W'(TIMEOUT - 1);
      end else if (state_q == ST_RUN && tmr_q != '0) begin
        tmr_q <= tmr_q - 1'b1;
      end

      if (commit) begin
        x_q  <= stage_wr[0 +: X_W];
        w1_q <= stage_wr[X_W +: W1_W];
        w2_q <= stage_wr[X_W + W1_W +: W2_W];
      end
    end
  end

  assign x_flat    = x_q;
  assign w1_flat   = w1_q;
  assign w2_flat   = w2_q;
  assign in_ready  = in_ready_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_gnn_in_loader.sv
// Directed bench for gnn_in_loader: load, RUN exit, timeout, framing errors,
// reset mid-frame and back-to-back staging.
module tb_gnn_in_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [15:0]  s_data = '0;
  logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0]   out_rdy = '0;
  logic [255:0] x_flat, w1_flat;
  logic [127:0] w2_flat;
  logic         in_ready, frame_err, timeout;

  logic [15:0]  sb_data = '0;
  logic         sb_valid = 1'b0, sb_last = 1'b0, sb_ready;
  logic [7:0]   out_rdy_b = '0;
  logic [255:0] x_flat_b, w1_flat_b;
  logic [127:0] w2_flat_b;
  logic         in_ready_b, frame_err_b, timeout_b;

  gnn_in_loader #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .out_rdy(out_rdy), .x_flat(x_flat), .w1_flat(w1_flat),
    .w2_flat(w2_flat), .in_ready(in_ready), .frame_err(frame_err), .timeout(timeout)
  );

  gnn_in_loader #(.TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .s_data(sb_data), .s_valid(sb_valid), .s_last(sb_last),
    .s_ready(sb_ready), .out_rdy(out_rdy_b), .x_flat(x_flat_b), .w1_flat(w1_flat_b),
    .w2_flat(w2_flat_b), .in_ready(in_ready_b), .frame_err(frame_err_b), .timeout(timeout_b)
  );

  int total = 0;
  int bad = 0;

  int fa_words [40] = '{4, 2, 4, 1, 6, 4, 4, 1, 8, 6, 4, 1, 6, 4, 4, 1,
                        3, 2, 13, 0, 0, 0, 0, 14, 3, 6, 0, 15, 9, 0, 15, 0,
                        0, 0, 3, 11, 12, 0, 0, 6};
  logic [639:0] frame_a, frame_b, frame_d, frame_e;

  task automatic put_word(input logic [15:0] d, input logic last);
    @(negedge clk);
    s_data = d; s_valid = 1'b1; s_last = last;
    @(posedge clk);
  endtask

  task automatic send_words(input logic [639:0] f, input int n, input int last_at);
    for (int k = 0; k < n; k++) put_word(f[16*k +: 16], k == last_at);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (x_flat !== 256'd0) begin bad++; $display("FAIL reset_x: got %h want 0", x_flat); end
    total++; if (w1_flat !== 256'd0 || w2_flat !== 128'd0) begin bad++; $display("FAIL reset_w: got %h %h want 0", w1_flat, w2_flat); end
    total++; if ({in_ready, frame_err, timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {in_ready, frame_err, timeout}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_load_frame;
    out_rdy = 8'hFF;
    send_words(frame_a, 39, -1);
    total++; if (x_flat !== 256'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL load_hold: got x=%h rdy=%b want 0", x_flat, in_ready); end
    put_word(frame_a[16*39 +: 16], 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_in_ready: got %b want 1", in_ready); end
    total++; if (x_flat[15:0] !== 16'd4) begin bad++; $display("FAIL load_x0: got %0d want 4", x_flat[15:0]); end
    total++; if (w1_flat[15:0] !== 16'd3) begin bad++; $display("FAIL load_w1_0: got %0d want 3", w1_flat[15:0]); end
    total++; if (w2_flat[127:112] !== 16'd6) begin bad++; $display("FAIL load_w2_7: got %0d want 6", w2_flat[127:112]); end
    total++; if (w1_flat[127:112] !== 16'd14) begin bad++; $display("FAIL load_w1_7: got %0d want 14", w1_flat[127:112]); end
    total++; if ({w2_flat, w1_flat, x_flat} !== frame_a) begin bad++; $display("FAIL load_all: got %h want %h", {w2_flat, w1_flat, x_flat}, frame_a); end
  endtask

  task automatic test_run_exit;
    int n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) n++; else break;
    end
    total++; if (n !== 2) begin bad++; $display("FAIL run_exit_len: got %0d want 2", n); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL run_exit_no_tmo: got %b want 0", timeout); end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL run_exit_load: got %b want 0", in_ready); end
  endtask

  task automatic test_frame_err;
    send_words(frame_b, 11, 10);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL err_early_pulse: got %b want 1", frame_err); end
    total++; if ({w2_flat, w1_flat, x_flat} !== frame_a) begin bad++; $display("FAIL err_early_hold: got %h want %h", {w2_flat, w1_flat, x_flat}, frame_a); end
    @(negedge clk);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL err_pulse_width: got %b want 0", frame_err); end
    send_words(frame_b, 40, -1);
    total++; if (frame_err !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL err_nolast: got err=%b rdy=%b want 1 0", frame_err, in_ready); end
    total++; if ({w2_flat, w1_flat, x_flat} !== frame_a) begin bad++; $display("FAIL err_nolast_hold: got %h want %h", {w2_flat, w1_flat, x_flat}, frame_a); end
    out_rdy = 8'h00;
    send_words(frame_b, 40, 39);
    total++; if (in_ready !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL err_recover_flags: got rdy=%b err=%b want 1 0", in_ready, frame_err); end
    total++; if (x_flat[95:80] !== 16'd16 || w1_flat[15:0] !== 16'd49 || w2_flat[15:0] !== 16'd97) begin
      bad++; $display("FAIL err_recover_slots: got %0d %0d %0d want 16 49 97", x_flat[95:80], w1_flat[15:0], w2_flat[15:0]); end
    total++; if ({w2_flat, w1_flat, x_flat} !== frame_b) begin bad++; $display("FAIL err_recover_all: got %h want %h", {w2_flat, w1_flat, x_flat}, frame_b); end
  endtask

  task automatic test_timeout;
    int n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) n++; else break;
    end
    total++; if (n !== 8) begin bad++; $display("FAIL tmo_len: got %0d want 8", n); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_pulse: got %b want 1", timeout); end
    @(negedge clk);
    total++; if (timeout !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL tmo_after: got tmo=%b rdy=%b want 0 0", timeout, in_ready); end
  endtask

  task automatic test_reset_mid;
    send_words(frame_e, 20, -1);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({w2_flat, w1_flat, x_flat} !== 640'd0) begin bad++; $display("FAIL rstmid_zero: got %h want 0", {w2_flat, w1_flat, x_flat}); end
    total++; if (s_ready !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got srdy=%b rdy=%b want 1 0", s_ready, in_ready); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (frame_err !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL rstmid_pulse: got err=%b tmo=%b want 0 0", frame_err, timeout); end
    send_words(frame_e, 40, 39);
    total++; if (in_ready !== 1'b1 || x_flat[63:48] !== 16'h5509) begin bad++; $display("FAIL rstmid_commit: got rdy=%b x3=%h want 1 5509", in_ready, x_flat[63:48]); end
    total++; if ({w2_flat, w1_flat, x_flat} !== frame_e) begin bad++; $display("FAIL rstmid_all: got %h want %h", {w2_flat, w1_flat, x_flat}, frame_e); end
  endtask

  task automatic test_back_to_back;
    out_rdy_b = 8'h00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); sb_data = frame_a[16*k +: 16]; sb_valid = 1'b1; sb_last = (k == 39);
      @(posedge clk);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); sb_data = frame_d[16*k +: 16]; sb_valid = 1'b1; sb_last = (k == 39);
      @(posedge clk);
    end
    @(negedge clk);
    sb_valid = 1'b0; sb_last = 1'b0;
    total++; if (sb_ready !== 1'b0 || in_ready_b !== 1'b1) begin bad++; $display("FAIL b2b_full: got srdy=%b rdy=%b want 0 1", sb_ready, in_ready_b); end
    total++; if ({w2_flat_b, w1_flat_b, x_flat_b} !== frame_a) begin bad++; $display("FAIL b2b_hold_run: got %h want %h", {w2_flat_b, w1_flat_b, x_flat_b}, frame_a); end
    out_rdy_b = 8'hFF;
    @(negedge clk);
    out_rdy_b = 8'h00;
    total++; if (in_ready_b !== 1'b0 || x_flat_b !== frame_a[255:0]) begin bad++; $display("FAIL b2b_gap: got rdy=%b x=%h", in_ready_b, x_flat_b); end
    @(negedge clk);
    total++; if (in_ready_b !== 1'b0 || sb_ready !== 1'b0 || x_flat_b !== frame_a[255:0]) begin
      bad++; $display("FAIL b2b_load: got rdy=%b srdy=%b x=%h", in_ready_b, sb_ready, x_flat_b); end
    @(negedge clk);
    total++; if (in_ready_b !== 1'b1 || sb_ready !== 1'b1) begin bad++; $display("FAIL b2b_commit_flags: got rdy=%b srdy=%b want 1 1", in_ready_b, sb_ready); end
    total++; if ({w2_flat_b, w1_flat_b, x_flat_b} !== frame_d) begin bad++; $display("FAIL b2b_commit_all: got %h want %h", {w2_flat_b, w1_flat_b, x_flat_b}, frame_d); end
    total++; if (w2_flat_b[127:112] !== 16'hA027) begin bad++; $display("FAIL b2b_w2_7: got %h want a027", w2_flat_b[127:112]); end
  endtask

  initial begin
    for (int k = 0; k < 40; k++) begin
      frame_a[16*k +: 16] = 16'(fa_words[k]);
      frame_b[16*k +: 16] = 16'(k * 3 + 1);
      frame_d[16*k +: 16] = 16'(16'hA000 + k);
      frame_e[16*k +: 16] = 16'(16'h5500 + k * k);
    end
    test_reset;
    test_load_frame;
    test_run_exit;
    test_frame_err;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/gnn_in_loader.md
GNN_IN_LOADER -- requirements
Module: gnn_in_loader

Interface
REQ-001 Parameter TIMEOUT, 64, max RUN cycles waiting for all gnn result flags before forced exit (range 2..65535).
REQ-002 Ports below; one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- s_data  input  16  stream word
- s_valid  input  1  word valid
- s_last  input  1  marks final word of a frame
- s_ready  output  1  loader accepts word this cycle
- out_rdy  input  8  out{0,1}_ready_node{0..3} from gnn; bit 2n = out0_ready_node n, bit 2n+1 = out1_ready_node n
- x_flat  output  256  features, word k at [16k+15:16k]
- w1_flat  output  256  layer-1 weights
- w2_flat  output  128  layer-2 weights
- in_ready  output  1  drives gnn in_ready
- frame_err  output  1  one-cycle pulse on framing error
- timeout  output  1  one-cycle pulse on RUN timeout

Function
REQ-003 A word transfers on an edge with s_valid=1 and s_ready=1; frame = 40 words, index k=0..39.
REQ-004 k 0..15 -> x{k%4}_node{k/4} at x_flat slot k.
REQ-005 k 16..31, m=k-16 -> w{m%4}{4+m/4} at w1_flat slot m (order w04,w14,w24,w34,w05,...,w37).
REQ-006 k 32..39, m=k-32 -> w{4+m%4}{8+m/4} at w2_flat slot m (order w48,w58,w68,w78,w49,...,w79).
REQ-007 Words assemble into a 640-bit staging buffer; x_flat/w1_flat/w2_flat change only at commit and hold stable otherwise.
REQ-008 States LOAD, RUN, GAP.
REQ-009 s_ready = !stage_full in every state (staging fills during RUN/GAP for back-to-back frames).
REQ-010 Word 39 accepted with s_last=1 completes a frame; if state is LOAD, commit on that same edge (outputs include word 39), in_ready<=1, state->RUN; otherwise set stage_full.
REQ-011 In LOAD with stage_full=1: commit, clear stage_full, in_ready<=1, ->RUN on the next edge.
REQ-012 RUN: in_ready=1; out_rdy ignored in the first RUN cycle; thereafter out_rdy==8'hFF -> GAP.
REQ-013 RUN timer counts RUN cycles; reaching TIMEOUT without exit pulses timeout and -> GAP; all-ready and timeout on the same cycle: exit counted as success, no timeout pulse.
REQ-014 GAP: exactly one cycle, in_ready=0, then -> LOAD.
REQ-015 s_last=1 on k<39, or k=39 with s_last=0: frame_err pulse next cycle, partial frame discarded, word counter -> 0, outputs and stage_full unchanged.
REQ-016 Word counter wraps to 0 after every completed or discarded frame.

Reset
REQ-017 rst=1 at any edge: state LOAD, counters 0, stage_full 0, staging and all flat outputs 0, in_ready 0, frame_err 0, timeout 0; s_ready=1 in the first cycle after reset.
REQ-018 Reset mid-frame or mid-RUN discards all in-progress data; no pulse is emitted for it.

Structure
REQ-019 Shared package gnn_pkg holds WORD_W=16, N_NODE=4, N_FEAT=4, N_HID=4, N_OUT=2, FRAME_WORDS=40 and the state enum.
REQ-020 One sub-module, gnn_frame_cnt: word counter with last-word and framing-error detection.

Verification
REQ-021 Frame 4,2,4,1,6,4,4,1,8,6,4,1,6,4,4,1 then w 3,2,13,0,0,0,0,14,3,6,0,15,9,0,15,0 then 0,0,3,11,12,0,0,6 from LOAD -> in_ready=1 after word 39 edge; x_flat slot0=4, w1_flat slot0=3, w2_flat slot7=6.
REQ-022 Same frame, out_rdy=8'hFF held from cycle 0 of RUN -> exit after exactly 2 RUN cycles, one GAP cycle with in_ready=0.
REQ-023 out_rdy held 0, TIMEOUT=8 -> timeout pulse after 8 RUN cycles, then GAP, then LOAD.
REQ-024 s_last on word 10 -> frame_err pulse, outputs unchanged; next clean 40-word frame commits correctly.
REQ-025 Second frame streamed during RUN -> s_ready drops after its word 39; commit occurs on the edge leaving GAP->LOAD+1 with new values.
REQ-026 rst asserted at word 20 -> all outputs 0, next full frame commits correctly.
